regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Debug/observation reader for the processor register file.
- On a start pulse it walks register indices 0..NUM_REGS-1 through one register-file read port.
- It captures each word and streams it out on a valid/ready interface with index and last markers.
- It sits beside the datapath and shares the combinational read port, so the external mux selects this block's address while busy=1.

Parameters:
- N, 32, data width of one register word
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers dumped; legal range 1..2^ADDR_W

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE
- rf_read_addr  output  ADDR_W  address driven to the register-file read port
- rf_read_data  input  N  combinational read data for rf_read_addr, valid the same cycle
- dump_valid  output  1  dump_data, dump_index and dump_last are valid
- dump_ready  input  1  consumer accepts the current word
- dump_data  output  N  captured register contents
- dump_index  output  ADDR_W  register index of dump_data
- dump_last  output  1  high with the final word (index NUM_REGS-1)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Clock and reset: clk, rising edge; reset is synchronous and active-high.
- Reset values: state=IDLE, idx=0, rf_read_addr=0, dump_valid=0, dump_data=0, dump_index=0, dump_last=0, busy=0, done=0.
- States are IDLE, READ, SEND and DONE.
- IDLE:
  - rf_read_addr=0, busy=0.
  - On start=1, load idx=0 and go to READ.
- READ:
  - rf_read_addr=idx, busy=1, dump_valid=0.
  - At the next edge: capture dump_data<=rf_read_data, dump_index<=idx, dump_last<=(idx==NUM_REGS-1), then go to SEND.
- SEND:
  - dump_valid=1.
  - dump_data, dump_index and dump_last hold stable until the handshake (dump_valid & dump_ready at an edge).
  - Handshake on a non-last word: idx<=idx+1, go to READ.
  - Handshake on the last word: go to DONE.
  - Without a handshake, remain in SEND.
- DONE: done=1 and busy=1 for exactly one cycle, then return to IDLE with idx=0.
- Throughput: 2 cycles per word when dump_ready is held high. With start sampled at edge T and dump_ready=1 throughout:
  - dump_valid first rises after edge T+1;
  - the last handshake occurs at edge T+2*NUM_REGS;
  - done is high for the following cycle.
- Snapshot semantics: each word is the register value in its READ cycle. Writes to that register after capture do not change the held dump_data. Writes to not-yet-read registers are visible when they are read.
- dump_ready while dump_valid=0 has no effect.
- start while busy=1 (including DONE) is ignored; it is not queued.
- dump_data and dump_index keep their last captured values after done; dump_valid=0 outside SEND.
- idx never exceeds NUM_REGS-1; no wrap-around occurs.
- NUM_REGS=1 gives a single word with dump_last=1.
- Reset mid-operation, in any state, forces the reset values at the next edge; the partial dump is abandoned and a fresh start begins at index 0.
- Simultaneous reset and start: reset wins; state is IDLE.

Test Plan:
- Full dump:
  - Stimulus: bench register model r0..r8=0x0..0x8, r9..r31=0; reset, then start pulse at edge T; dump_ready=1.
  - Required response: 32 handshakes with dump_index k and dump_data=model[k]; dump_last only at k=31; last handshake at edge T+64; done high one cycle; busy=0 afterwards.
- Backpressure:
  - Stimulus: dump_ready=0 for 5 cycles while word 3 is presented.
  - Required response: dump_valid=1, dump_data=0x3 and dump_index=3 stable all 5 cycles; rf_read_addr stays 3; word 4 is not read until word 3 is accepted.
- Snapshot:
  - Stimulus: while word 3 is held, the bench writes r3=0xDEADBEEF and r5=0x12345678.
  - Required response: word 3 still 0x00000003; word 5 emits 0x12345678.
- Start while busy:
  - Stimulus: extra start pulses during word 7 and during DONE.
  - Required response: no restart, no index discontinuity, exactly one done.
  - Follow-up: a start after done produces a second complete 0..31 dump.
- Reset mid-dump:
  - Stimulus: assert reset while in SEND on word 10.
  - Required response: at the next edge dump_valid=0, busy=0, dump_index=0, dump_data=0, done never pulses.
  - Follow-up: a new start emits index 0 first.
- Parameter variant:
  - Stimulus: NUM_REGS=8, ready toggling 1,0,1,0.
  - Required response: exactly 8 words (indices 0..7), dump_last only on 7, done once, rf_read_addr never exceeds 7.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks indices 0..NUM_REGS-1 through one
// read port and streams each captured word out on a valid/ready channel.
module regfile_dump_reader #(
  parameter int N        = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [N-1:0]      rf_read_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [N-1:0]      dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              hs;

  assign hs = dump_valid & dump_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = READ;
      READ: state_nxt = SEND;
      SEND: if (hs) state_nxt = dump_last ? DONE : READ;
      DONE: state_nxt = IDLE;
    endcase
  end

  // Captured word is held until accepted, so later writes cannot disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      dump_data  <= '0;
      dump_index <= '0;
      dump_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) idx <= '0;
        READ: begin
          dump_data  <= rf_read_data;
          dump_index <= idx;
          dump_last  <= (idx == LAST_IDX);
        end
        SEND: if (hs && !dump_last) idx <= idx + 1'b1;
        DONE: idx <= '0;
      endcase
    end
  end

  always_comb begin
    rf_read_addr = '0;
    dump_valid   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: ;
      READ: begin
        rf_read_addr = idx;
        busy         = 1'b1;
      end
      SEND: begin
        rf_read_addr = idx;
        dump_valid   = 1'b1;
        busy         = 1'b1;
      end
      DONE: begin
        rf_read_addr = idx;
        busy         = 1'b1;
        done         = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a 32-register and an 8-register instance
// checked against a transaction-level model of the dump sequence.
module tb_regfile_dump_reader;

  logic            clk = 1'b0;
  logic [1:0]      rst;
  logic [1:0]      start;
  logic [1:0]      ready;
  logic [1:0][4:0] addr;
  logic [1:0][31:0] rdata;
  logic [1:0]      valid;
  logic [1:0][31:0] data;
  logic [1:0][4:0] index;
  logic [1:0]      last;
  logic [1:0]      busy;
  logic [1:0]      done;

  logic [31:0] rf   [2][32];
  logic [31:0] snap [2][32];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_on = 0;

  int mode   [2];
  bit wr_en  [2];
  bit in_dump[2];
  bit dpend  [2];
  int exp_idx[2];
  int words  [2];
  int n_done [2];
  int t_start[2];
  int last_hs[2];
  bit hold   [2];
  logic [31:0] h_data[2];
  logic [4:0]  h_idx [2];
  logic        h_last[2];

  always #5 clk = ~clk;

  assign rdata[0] = rf[0][addr[0]];
  assign rdata[1] = rf[1][addr[1]];

  regfile_dump_reader #(.N(32), .ADDR_W(5), .NUM_REGS(32)) u_dut0 (
    .clk(clk), .reset(rst[0]), .start(start[0]),
    .rf_read_addr(addr[0]), .rf_read_data(rdata[0]),
    .dump_valid(valid[0]), .dump_ready(ready[0]),
    .dump_data(data[0]), .dump_index(index[0]),
    .dump_last(last[0]), .busy(busy[0]), .done(done[0])
  );

  regfile_dump_reader #(.N(32), .ADDR_W(5), .NUM_REGS(8)) u_dut1 (
    .clk(clk), .reset(rst[1]), .start(start[1]),
    .rf_read_addr(addr[1]), .rf_read_data(rdata[1]),
    .dump_valid(valid[1]), .dump_ready(ready[1]),
    .dump_data(data[1]), .dump_index(index[1]),
    .dump_last(last[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic int nr(input int d);
    return (d == 0) ? 32 : 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Registers above the held word are still unread, so they follow writes
  task automatic wr(input int d, input int k, input logic [31:0] v);
    rf[d][k] = v;
    if (in_dump[d] && valid[d] && k > exp_idx[d]) snap[d][k] = v;
  endtask

  task automatic step();
    bit hs[2];
    bit was_busy[2];
    for (int d = 0; d < 2; d++) begin
      if (mode[d] == 1) ready[d] = 1'($urandom_range(0, 1));
      else if (mode[d] == 2) ready[d] = (cyc % 2 == 0);
      if (wr_en[d] && valid[d] && $urandom_range(0, 3) == 0)
        wr(d, $urandom_range(0, nr(d) - 1), $urandom);
    end
    #0;
    for (int d = 0; d < 2; d++) begin
      hs[d] = 0;
      was_busy[d] = in_dump[d];
      if (!chk_on) continue;
      chk($sformatf("busy%0d", d), busy[d], in_dump[d]);
      chk($sformatf("done%0d", d), done[d], dpend[d]);
      if (done[d]) n_done[d]++;
      chk($sformatf("addr_max%0d", d), addr[d] <= 5'(nr(d) - 1), 1);
      if (valid[d]) begin
        chk($sformatf("valid_ctx%0d", d), in_dump[d] && !dpend[d], 1);
        chk($sformatf("addr_held%0d", d), addr[d], index[d]);
      end
      if (hold[d]) begin
        chk($sformatf("hold_valid%0d", d), valid[d], 1);
        chk($sformatf("hold_data%0d", d), data[d], h_data[d]);
        chk($sformatf("hold_idx%0d", d), index[d], h_idx[d]);
        chk($sformatf("hold_last%0d", d), last[d], h_last[d]);
      end
      hs[d] = valid[d] && ready[d];
      if (hs[d]) begin
        chk($sformatf("idx%0d", d), index[d], exp_idx[d]);
        chk($sformatf("data%0d_%0d", d, exp_idx[d]), data[d],
            snap[d][exp_idx[d]]);
        chk($sformatf("last%0d_%0d", d, exp_idx[d]), last[d],
            exp_idx[d] == nr(d) - 1);
        words[d]++;
        last_hs[d] = cyc + 1;
      end
      hold[d]   = valid[d] && !ready[d];
      h_data[d] = data[d];
      h_idx[d]  = index[d];
      h_last[d] = last[d];
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        in_dump[d] = 0;
        dpend[d]   = 0;
        exp_idx[d] = 0;
        hold[d]    = 0;
      end else begin
        if (dpend[d]) begin
          dpend[d]   = 0;
          in_dump[d] = 0;
        end else if (hs[d]) begin
          if (exp_idx[d] == nr(d) - 1) dpend[d] = 1;
          else exp_idx[d]++;
        end
        if (start[d] && !was_busy[d]) begin
          in_dump[d] = 1;
          exp_idx[d] = 0;
          words[d]   = 0;
          t_start[d] = cyc;
          for (int k = 0; k < 32; k++) snap[d][k] = rf[d][k];
        end
      end
    end
  endtask

  task automatic start_dump(input int d);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
  endtask

  task automatic wait_word(input int d, input int k);
    int n = 0;
    while (!(valid[d] && index[d] == 5'(k)) && n < 300) begin
      step();
      n++;
    end
    if (!(valid[d] && index[d] == 5'(k)))
      chk($sformatf("word_timeout%0d_%0d", d, k), 0, 1);
  endtask

  task automatic run_to_done(input int d);
    int n = 0;
    while (!done[d] && n < 800) begin
      step();
      n++;
    end
    if (!done[d]) chk($sformatf("done_timeout%0d", d), 0, 1);
    step();
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_valid"}, valid[d], 0);
    chk({tag, "_busy"}, busy[d], 0);
    chk({tag, "_done"}, done[d], 0);
    chk({tag, "_index"}, index[d], 0);
    chk({tag, "_data"}, data[d], 0);
    chk({tag, "_last"}, last[d], 0);
    chk({tag, "_addr"}, addr[d], 0);
  endtask

  initial begin
    int nd;
    rst   = 2'b11;
    start = 2'b00;
    ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      mode[d] = 0;    wr_en[d] = 0;  in_dump[d] = 0; dpend[d] = 0;
      exp_idx[d] = 0; words[d] = 0;  n_done[d] = 0;  hold[d] = 0;
      for (int k = 0; k < 32; k++) rf[d][k] = '0;
    end
    for (int k = 0; k < 9; k++) rf[0][k] = 32'(k);
    for (int k = 0; k < 8; k++) rf[1][k] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1;
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");
    rst = 2'b00;
    step();

    start_dump(0);
    run_to_done(0);
    chk("full_words", words[0], 32);
    chk("full_latency", last_hs[0] - t_start[0], 64);
    chk("full_ndone", n_done[0], 1);
    step();
    chk("full_idle", busy[0], 0);

    start_dump(0);
    wait_word(0, 3);
    ready[0] = 1'b0;
    wr(0, 3, 32'hDEADBEEF);
    wr(0, 5, 32'h12345678);
    repeat (5) begin
      chk("bp_valid", valid[0], 1);
      chk("bp_data", data[0], 32'h3);
      chk("bp_index", index[0], 3);
      chk("bp_addr", addr[0], 3);
      step();
    end
    ready[0] = 1'b1;
    wait_word(0, 5);
    chk("snap_word5", data[0], 32'h12345678);
    run_to_done(0);
    chk("bp_words", words[0], 32);

    nd = n_done[0];
    start_dump(0);
    wait_word(0, 7);
    start_dump(0);
    begin
      int n = 0;
      while (!done[0] && n < 200) begin
        step();
        n++;
      end
    end
    chk("busy_in_done", done[0], 1);
    start_dump(0);
    repeat (3) step();
    chk("busy_ndone", n_done[0] - nd, 1);
    chk("busy_words", words[0], 32);
    chk("busy_idle", busy[0], 0);
    start_dump(0);
    run_to_done(0);
    chk("again_words", words[0], 32);

    start_dump(0);
    wait_word(0, 10);
    ready[0] = 1'b0;
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk_reset(0, "midrst");
    nd = n_done[0];
    repeat (4) step();
    chk("midrst_nodone", n_done[0], nd);
    ready[0] = 1'b1;
    start_dump(0);
    step();
    chk("midrst_first_valid", valid[0], 1);
    chk("midrst_first_idx", index[0], 0);
    run_to_done(0);
    chk("midrst_words", words[0], 32);

    mode[0] = 1;
    wr_en[0] = 1;
    repeat (3) begin
      start_dump(0);
      run_to_done(0);
      chk("rnd_words0", words[0], 32);
    end
    mode[0] = 0;
    wr_en[0] = 0;
    ready[0] = 1'b1;

    mode[1] = 2;
    start_dump(1);
    run_to_done(1);
    chk("p8_words", words[1], 8);
    chk("p8_ndone", n_done[1], 1);
    step();
    chk("p8_idle", busy[1], 0);
    mode[1] = 1;
    wr_en[1] = 1;
    repeat (2) begin
      start_dump(1);
      run_to_done(1);
      chk("rnd_words1", words[1], 8);
    end
    chk("p8_ndone_total", n_done[1], 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
